// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path (and a future receiver).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clock cycles per line bit; integer truncation is intentional.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_restart,
    input  logic i_enable,
    output logic o_bit_end
);

    localparam int TW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);

    logic [TW-1:0] r_timer;
    logic          w_at_last;

    assign w_at_last = (r_timer == TW'(CLKS_PER_BIT - 1));
    assign o_bit_end = i_enable && !i_restart && w_at_last;

    // Timer: held at zero on restart, wraps to zero at the end of every bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_timer <= '0;
        end else if (i_restart) begin
            r_timer <= '0;
        end else if (i_enable) begin
            if (w_at_last) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: 5..9 data bits, optional parity, 1 or 2 stop bits,
// with a one-entry holding register so frames can go out back-to-back.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 tx_busy,
    output logic                 frame_done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD_RATE);
    localparam int CNT_W        = 4;

    if (CLKS_PER_BIT < 2) begin : g_chk_cpb
        $fatal(1, "uart_tx_frame: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_db
        $fatal(1, "uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < PAR_NONE || PARITY_MODE > PAR_EVEN) begin : g_chk_par
        $fatal(1, "uart_tx_frame: PARITY_MODE must be 0..2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
        $fatal(1, "uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    state_t               r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_hold;
    logic                 r_hold_full;
    logic                 r_parity;
    logic                 r_txd;
    logic [CNT_W-1:0]     r_bit_cnt;

    logic w_bit_end;
    logic w_handshake;
    logic w_last_data;
    logic w_last_stop;
    logic w_idle;

    // Parity bit over exactly DATA_BITS bits of the byte.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
        return (PARITY_MODE == PAR_EVEN) ? ^d : ~^d;
    endfunction

    assign w_idle      = (r_state == IDLE);
    assign w_handshake = tx_valid && !r_hold_full;
    assign w_last_data = (r_bit_cnt == CNT_W'(DATA_BITS - 1));
    assign w_last_stop = (STOP_BITS == 1) || (r_bit_cnt == CNT_W'(1));

    assign tx_ready   = !r_hold_full;
    assign txd        = r_txd;
    assign tx_busy    = !w_idle;
    assign frame_done = (r_state == STOP) && w_last_stop && w_bit_end;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_restart(w_idle),
        .i_enable (!w_idle),
        .o_bit_end(w_bit_end)
    );

    // Frame FSM with shift register, hold register and registered line output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_parity    <= 1'b0;
            r_txd       <= 1'b1;
            r_bit_cnt   <= '0;
        end else begin
            if (w_handshake && !w_idle) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_bit_cnt <= '0;
                    if (r_hold_full) begin
                        r_shift     <= r_hold;
                        r_parity    <= calc_parity(r_hold);
                        r_hold_full <= 1'b0;
                        r_txd       <= 1'b0;
                        r_state     <= START;
                    end else if (w_handshake) begin
                        r_shift  <= tx_data;
                        r_parity <= calc_parity(tx_data);
                        r_txd    <= 1'b0;
                        r_state  <= START;
                    end
                end

                START: begin
                    if (w_bit_end) begin
                        r_txd     <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= '0;
                        r_state   <= DATA;
                    end
                end

                DATA: begin
                    if (w_bit_end) begin
                        if (w_last_data) begin
                            r_bit_cnt <= '0;
                            if (PARITY_MODE != PAR_NONE) begin
                                r_txd   <= r_parity;
                                r_state <= PARITY;
                            end else begin
                                r_txd   <= 1'b1;
                                r_state <= STOP;
                            end
                        end else begin
                            r_txd     <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                end

                PARITY: begin
                    if (w_bit_end) begin
                        r_txd     <= 1'b1;
                        r_bit_cnt <= '0;
                        r_state   <= STOP;
                    end
                end

                STOP: begin
                    if (w_bit_end) begin
                        if (w_last_stop) begin
                            r_bit_cnt <= '0;
                            if (r_hold_full) begin
                                r_shift     <= r_hold;
                                r_parity    <= calc_parity(r_hold);
                                r_hold_full <= 1'b0;
                                r_txd       <= 1'b0;
                                r_state     <= START;
                            end else begin
                                r_txd   <= 1'b1;
                                r_state <= IDLE;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    r_txd   <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations (8N1, 8E1, 8O1, 9N2) at 8 clocks/bit,
// directed frames with literal line patterns plus randomized traffic against a
// frame-level reference model.
module tb_uart_tx_frame;

    localparam int C = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] v;
    logic [8:0] dat [4];
    logic [3:0] rdy, txd, bsy, fd;

    int tests;
    int fails;

    int DBc [4] = '{8, 8, 8, 9};
    int PMc [4] = '{0, 2, 1, 0};
    int SBc [4] = '{1, 1, 1, 2};

    // Reference model: current frame as a list of line bits plus a cycle position.
    bit         m_busy  [4];
    int         m_pos   [4];
    int         m_len   [4];
    bit         m_bits  [4][16];
    bit         m_holdv [4];
    logic [8:0] m_holdd [4];

    uart_tx_frame #(.CLK_HZ(8), .BAUD_RATE(1), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .tx_valid(v[0]), .tx_data(dat[0][7:0]),
        .tx_ready(rdy[0]), .txd(txd[0]), .tx_busy(bsy[0]), .frame_done(fd[0]));
    uart_tx_frame #(.CLK_HZ(8), .BAUD_RATE(1), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tx_valid(v[1]), .tx_data(dat[1][7:0]),
        .tx_ready(rdy[1]), .txd(txd[1]), .tx_busy(bsy[1]), .frame_done(fd[1]));
    uart_tx_frame #(.CLK_HZ(8), .BAUD_RATE(1), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .tx_valid(v[2]), .tx_data(dat[2][7:0]),
        .tx_ready(rdy[2]), .txd(txd[2]), .tx_busy(bsy[2]), .frame_done(fd[2]));
    uart_tx_frame #(.CLK_HZ(8), .BAUD_RATE(1), .DATA_BITS(9), .PARITY_MODE(0), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .tx_valid(v[3]), .tx_data(dat[3]),
        .tx_ready(rdy[3]), .txd(txd[3]), .tx_busy(bsy[3]), .frame_done(fd[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic void m_reset(input int i);
        m_busy[i]  = 1'b0;
        m_pos[i]   = 0;
        m_len[i]   = 0;
        m_holdv[i] = 1'b0;
        m_holdd[i] = '0;
    endfunction

    // Build the line-bit list of one frame straight from the framing rules.
    function automatic void m_start(input int i, input logic [8:0] d);
        int  n;
        bit  p;
        p = 1'b0;
        m_bits[i][0] = 1'b0;
        for (int j = 0; j < DBc[i]; j++) begin
            m_bits[i][1+j] = d[j];
            p ^= d[j];
        end
        n = 1 + DBc[i];
        if (PMc[i] != 0) begin
            m_bits[i][n] = (PMc[i] == 2) ? p : ~p;
            n++;
        end
        for (int s = 0; s < SBc[i]; s++) m_bits[i][n+s] = 1'b1;
        n += SBc[i];
        m_len[i]  = n * C;
        m_pos[i]  = 0;
        m_busy[i] = 1'b1;
    endfunction

    // One clock of model time, using the inputs the DUT will sample at the next edge.
    function automatic void m_step(input int i, input bit valid, input logic [8:0] d);
        bit hs;
        hs = valid && !m_holdv[i];
        if (!m_busy[i]) begin
            if (m_holdv[i]) begin
                m_start(i, m_holdd[i]);
                m_holdv[i] = 1'b0;
            end else if (hs) begin
                m_start(i, d);
            end
        end else if (m_pos[i] == m_len[i] - 1) begin
            if (m_holdv[i]) begin
                m_start(i, m_holdd[i]);
                m_holdv[i] = 1'b0;
            end else begin
                m_busy[i] = 1'b0;
                if (hs) begin
                    m_holdv[i] = 1'b1;
                    m_holdd[i] = d;
                end
            end
        end else begin
            m_pos[i]++;
            if (hs) begin
                m_holdv[i] = 1'b1;
                m_holdd[i] = d;
            end
        end
    endfunction

    // Compare process: every falling edge, all four DUTs against the model.
    initial begin
        for (int i = 0; i < 4; i++) m_reset(i);
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (!rst_n) m_reset(i);
                chk("m_txd",   int'(txd[i]), m_busy[i] ? int'(m_bits[i][m_pos[i] / C]) : 1);
                chk("m_busy",  int'(bsy[i]), int'(m_busy[i]));
                chk("m_ready", int'(rdy[i]), int'(!m_holdv[i]));
                chk("m_done",  int'(fd[i]),  int'(m_busy[i] && (m_pos[i] == m_len[i] - 1)));
                if (rst_n) m_step(i, v[i], dat[i]);
            end
        end
    end

    // Present a byte; returns one time unit after the handshake edge with valid still high.
    task automatic present(input int i, input logic [8:0] d);
        @(posedge clk);
        #1;
        v[i]   = 1'b1;
        dat[i] = d;
        @(posedge clk);
        #1;
    endtask

    // Watch a frame sequence with literal expectations; cycle 0 is the first start-bit cycle.
    task automatic watch(input int i, input logic [31:0] pat, input int nbits, input int fbits,
                         input int ncyc, input int drop_k, input int wig_k, input string tag);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (k == 0) chk({tag, "_start_lat"}, int'(txd[i]), 0);
            if ((k % C) == C / 2 && (k / C) < nbits)
                chk({tag, "_bit"}, int'(txd[i]), int'(pat[k / C]));
            chk({tag, "_busy"}, int'(bsy[i]), int'(k < nbits * C));
            chk({tag, "_done"}, int'(fd[i]), int'((k < nbits * C) && (((k + 1) % (fbits * C)) == 0)));
            if (wig_k > 0 && k >= 1 && k < fbits * C)
                chk({tag, "_ready_low"}, int'(rdy[i]), 0);
            @(posedge clk);
            #1;
            if (k < wig_k) dat[i] = 9'($urandom);
            if (k == drop_k) begin
                v[i]   = 1'b0;
                dat[i] = 9'($urandom);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        v     = '0;
        for (int i = 0; i < 4; i++) dat[i] = '0;

        // Reset values.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("rst_txd",   int'(txd[i]), 1);
            chk("rst_ready", int'(rdy[i]), 1);
            chk("rst_busy",  int'(bsy[i]), 0);
            chk("rst_done",  int'(fd[i]),  0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // 0xA5, 8N1.
        present(0, 9'h0A5);
        v[0] = 1'b0; dat[0] = 9'($urandom);
        watch(0, 32'b1101001010, 10, 10, 81, -1, 0, "a5_8n1");

        // 0x07 with even and odd parity, launched together.
        @(posedge clk);
        #1;
        v[1] = 1'b1; dat[1] = 9'h007;
        v[2] = 1'b1; dat[2] = 9'h007;
        @(posedge clk);
        #1;
        v[1] = 1'b0; v[2] = 1'b0;
        fork
            watch(1, 32'b11000001110, 11, 11, 89, -1, 0, "07_even");
            watch(2, 32'b10000001110, 11, 11, 89, -1, 0, "07_odd");
        join

        // Back-to-back 0x11 then 0x22 with valid held.
        present(0, 9'h011);
        dat[0] = 9'h022;
        watch(0, {12'b0, 10'b1001000100, 10'b1000100010}, 20, 10, 161, 0, 0, "b2b");

        // 9 data bits, 2 stop bits.
        present(3, 9'h1FF);
        v[3] = 1'b0; dat[3] = 9'($urandom);
        watch(3, 32'b111111111110, 12, 12, 97, -1, 0, "9n2");

        // Hold full while tx_data wiggles: 0x3C then held 0xC3.
        present(0, 9'h03C);
        dat[0] = 9'h0C3;
        watch(0, {12'b0, 10'b1110000110, 10'b1001111000}, 20, 10, 161, 70, 70, "hold");

        // Async reset during data bit 3 of 0xF0.
        present(0, 9'h0F0);
        v[0] = 1'b0;
        repeat (35) @(posedge clk);
        #2;
        chk("rst_pre_txd", int'(txd[0]), 0);
        chk("rst_pre_busy", int'(bsy[0]), 1);
        rst_n = 1'b0;
        #1;
        chk("async_txd",   int'(txd[0]), 1);
        chk("async_ready", int'(rdy[0]), 1);
        chk("async_busy",  int'(bsy[0]), 0);
        chk("async_done",  int'(fd[0]),  0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            chk("post_rst_txd", int'(txd[0]), 1);
        end

        // Randomized traffic on all four, varying offered load.
        for (int seg = 0; seg < 4; seg++) begin
            for (int cyc = 0; cyc < 800; cyc++) begin
                @(posedge clk);
                #1;
                for (int i = 0; i < 4; i++) begin
                    v[i]   = ($urandom_range(0, 7) < seg * 2 + 1);
                    dat[i] = 9'($urandom);
                end
            end
        end
        @(posedge clk);
        #1;
        v = '0;
        repeat (250) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("drain_busy",  int'(bsy[i]), 0);
            chk("drain_ready", int'(rdy[i]), 1);
            chk("drain_txd",   int'(txd[i]), 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
